// File: rtl/countdown_timer_bcd.sv
// MM:SS BCD countdown timer driven by rising edges of the divided 1 Hz Tick,
// sampled in the Clk domain. Load/Start/Pause are edge-triggered commands.
module countdown_timer_bcd #(
  parameter int ALARM_TICKS = 3
) (
  input  logic       Clk,
  input  logic       Rst,
  input  logic       Tick,
  input  logic       Load,
  input  logic       Start,
  input  logic       Pause,
  input  logic [7:0] MinIn,
  input  logic [7:0] SecIn,
  output logic [3:0] MinTens,
  output logic [3:0] MinOnes,
  output logic [3:0] SecTens,
  output logic [3:0] SecOnes,
  output logic       Running,
  output logic       Done,
  output logic       Alarm
);

  typedef enum logic [1:0] {IDLE, RUN, PAUSE, DONE} state_t;

  localparam logic [3:0] ALARM_LIM = 4'(ALARM_TICKS);

  state_t      state, state_nxt;
  logic [15:0] count, count_nxt;
  logic [3:0]  alarm_cnt, alarm_cnt_nxt;
  logic        alarm_nxt;
  logic        tick_prev, load_prev, start_prev, pause_prev;
  logic        tick_rise, load_rise, start_rise, pause_rise;
  logic [15:0] count_dec, count_load;

  function automatic logic [3:0] clamp_digit(input logic [3:0] d, input logic [3:0] lim);
    return (d > lim) ? lim : d;
  endfunction

  // BCD borrow chain; a zero count stays at zero so the timer can never wrap
  function automatic logic [15:0] bcd_dec(input logic [15:0] c);
    logic [3:0] mt, mo, st, so;
    {mt, mo, st, so} = c;
    if (c == 16'h0000) return c;
    if (so != 4'd0) so = so - 4'd1;
    else begin
      so = 4'd9;
      if (st != 4'd0) st = st - 4'd1;
      else begin
        st = 4'd5;
        if (mo != 4'd0) mo = mo - 4'd1;
        else begin
          mo = 4'd9;
          mt = mt - 4'd1;
        end
      end
    end
    return {mt, mo, st, so};
  endfunction

  assign tick_rise  = Tick  & ~tick_prev;
  assign load_rise  = Load  & ~load_prev;
  assign start_rise = Start & ~start_prev;
  assign pause_rise = Pause & ~pause_prev;

  assign count_dec  = bcd_dec(count);
  assign count_load = {clamp_digit(MinIn[7:4], 4'd9), clamp_digit(MinIn[3:0], 4'd9),
                       clamp_digit(SecIn[7:4], 4'd5), clamp_digit(SecIn[3:0], 4'd9)};

  // Prev-registers reset high so inputs already asserted at reset release are not edges
  always_ff @(posedge Clk) begin
    if (!Rst) begin
      state      <= IDLE;
      count      <= 16'h0000;
      alarm_cnt  <= 4'd0;
      Alarm      <= 1'b0;
      tick_prev  <= 1'b1;
      load_prev  <= 1'b1;
      start_prev <= 1'b1;
      pause_prev <= 1'b1;
    end else begin
      state      <= state_nxt;
      count      <= count_nxt;
      alarm_cnt  <= alarm_cnt_nxt;
      Alarm      <= alarm_nxt;
      tick_prev  <= Tick;
      load_prev  <= Load;
      start_prev <= Start;
      pause_prev <= Pause;
    end
  end

  always_comb begin
    state_nxt     = state;
    count_nxt     = count;
    alarm_cnt_nxt = alarm_cnt;
    alarm_nxt     = Alarm;
    if (load_rise) begin
      state_nxt     = IDLE;
      count_nxt     = count_load;
      alarm_cnt_nxt = 4'd0;
      alarm_nxt     = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start_rise && count != 16'h0000) state_nxt = RUN;
        end
        RUN: begin
          if (tick_rise) count_nxt = count_dec;
          // Reaching zero wins over a coincident pause
          if (tick_rise && count_dec == 16'h0000) begin
            state_nxt     = DONE;
            alarm_nxt     = 1'b1;
            alarm_cnt_nxt = 4'd0;
          end else if (pause_rise) begin
            state_nxt = PAUSE;
          end
        end
        PAUSE: begin
          if (start_rise) state_nxt = RUN;
        end
        DONE: begin
          if (tick_rise && alarm_cnt < ALARM_LIM) begin
            alarm_cnt_nxt = alarm_cnt + 4'd1;
            if (alarm_cnt + 4'd1 == ALARM_LIM) alarm_nxt = 1'b0;
          end
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

  assign {MinTens, MinOnes, SecTens, SecOnes} = count;
  assign Running = (state == RUN);
  assign Done    = (state == DONE);

endmodule

// File: doc/countdown_timer_bcd.md
Name: countdown_timer_bcd

Overview:
Downstream consumer of the 1 Hz clock-divider output. Samples the slow divided clock (Tick) in the fast Clk domain and uses its rising edges as count enables, so the block runs on the board clock only. Implements a load/start/pause MM:SS countdown timer with BCD digit outputs that feed the 7-segment display mux. Raises Done and a bounded Alarm when the count reaches 00:00.

Parameters:
ALARM_TICKS, 3, number of Tick rising edges for which Alarm stays high after reaching 00:00 (1..15)

Ports:
Clk  in  1  board clock (100 MHz)
Rst  in  1  synchronous reset, active-low; sampled on posedge Clk
Tick  in  1  divided clock from the clock divider, registered in Clk domain; only its rising edges count
Load  in  1  level input (already debounced); its rising edge loads MinIn/SecIn
Start  in  1  level input (debounced); its rising edge starts or resumes
Pause  in  1  level input (debounced); its rising edge pauses
MinIn  in  8  BCD minutes, [7:4]=tens, [3:0]=ones
SecIn  in  8  BCD seconds, [7:4]=tens, [3:0]=ones
MinTens, MinOnes, SecTens, SecOnes  out  4 each  current BCD count, registered
Running  out  1  high in RUN state
Done  out  1  high in DONE state
Alarm  out  1  high for the first ALARM_TICKS tick edges of DONE

Behaviour:
- One clock (Clk), all state updates on posedge Clk. Rst is synchronous and active-low: Rst==0 at a Clk edge resets the block. Reset takes priority over every other input, including mid-count.
- Reset values: all digits 0, state IDLE, Running=0, Done=0, Alarm=0, alarm counter 0.
- Edge detect: each of Tick, Load, Start and Pause has a prev-register. rise = in & ~prev. Prev-registers reset to 1, so an input already high at reset release produces no edge.
- Latency: the Clk edge at which a rise is true applies the action. Outputs change 1 Clk after the input goes high.
- Load clamp: any digit above 9 loads as 9. SecIn tens above 5 loads as 5. Example: MinIn=8'hA7 and SecIn=8'h7C load as 97:59.
- Command priority on the same edge: Load > Start > Pause.
- States:
  - IDLE:
    - Load rise -> load clamped value, stay IDLE.
    - Start rise with nonzero count -> RUN.
    - Start rise with count 00:00 -> ignored.
    - Tick ignored.
  - RUN:
    - Tick rise -> decrement one second with BCD borrow chain (SecOnes 0->9 borrows SecTens; SecTens 0->5 borrows MinOnes; MinOnes 0->9 borrows MinTens).
    - Decrement from 00:01 -> 00:00 and enter DONE on the same edge; Alarm=1; alarm counter=0.
    - Pause rise -> PAUSE. If Tick rise falls on the same edge, the decrement is also applied.
    - Load rise -> load value, go to IDLE, no decrement.
    - Start rise -> ignored.
  - PAUSE:
    - Start rise -> RUN.
    - Load rise -> load value, go to IDLE.
    - Tick and Pause ignored; digits hold.
  - DONE:
    - Digits hold at 00:00.
    - Each Tick rise increments the alarm counter. When the counter reaches ALARM_TICKS, Alarm drops to 0 and stays 0.
    - Load rise -> load value, go to IDLE, Done=0, Alarm=0.
    - Start and Pause ignored.
- The count never underflows below 00:00 and never wraps. The maximum loadable value is 99:59.

Test Plan:
- Reset: hold Rst=0 for 3 Clk with Load/Start high -> all digits 0, Running=Done=Alarm=0. Release Rst with inputs still high -> no load and no start occurs.
- Load 01:00, pulse Start, apply 1 Tick rise -> Running=1 and display reads 00:59. Check SecTens 0->5 borrow and MinOnes 1->0.
- Load 00:02, Start, 2 Tick rises -> 00:01 then 00:00, Done=1, Running=0, Alarm=1. Alarm stays 1 for 3 more Tick rises and drops on the 3rd. Further ticks leave digits at 00:00.
- Load 10:00, Start, 1 tick -> 09:59. Pause, then 5 Tick rises -> holds 09:59. Start, 1 tick -> 09:58.
- Clamp and priority: MinIn=8'hFF, SecIn=8'h9A with Load and Start rising on the same edge -> IDLE with 99:59. Then Start -> RUN. Load 00:05 coinciding with a Tick rise in RUN -> IDLE showing 00:05, no decrement.
- Mid-run reset: RUN at 00:30, assert Rst=0 for 1 Clk -> IDLE, 00:00, all flags low. Start rise with count 00:00 -> stays IDLE.
